// File: rtl/urv_wb_stage.sv
// urv_wb_stage: writeback stage that sits directly after the execute stage.
// Holds the pipeline while a data-memory access completes. Aligns and
// extends load data. Issues one registered register-file write per
// retired instruction.
//
// Optional feature (compile-time macro URV_WB_TIMEOUT_EN):
//   When defined, a 16-bit counter watches WAIT_MEM cycles that have no done
//   strobe. When the counter reaches TIMEOUT_CYCLES, the access is
//   force-completed with load data taken as zero, and w_bus_err_o pulses for
//   one cycle.
//   When undefined, WAIT_MEM waits indefinitely and w_bus_err_o is tied low.
module urv_wb_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        x_stall_i,
  input  logic        w_valid_i,
  input  logic [2:0]  w_fun_i,
  input  logic        w_load_i,
  input  logic        w_store_i,
  input  logic [4:0]  w_rd_i,
  input  logic        w_rd_write_i,
  input  logic [31:0] w_rd_value_i,
  input  logic [1:0]  w_rd_source_i,
  input  logic [31:0] w_rd_shifter_i,
  input  logic [31:0] w_rd_multiply_i,
  input  logic [31:0] w_dm_addr_i,
  input  logic [31:0] dm_data_l_i,
  input  logic        dm_load_done_i,
  input  logic        dm_store_done_i,
  output logic        w_stall_req_o,
  output logic        rf_rd_write_o,
  output logic [4:0]  rf_rd_o,
  output logic [31:0] rf_rd_value_o,
  output logic        w_bus_err_o
);

  // HELD covers the cycles after a commit while execute is still frozen. The
  // w_* inputs still show the retired instruction during those cycles, so
  // they must be ignored.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_MEM,
    ST_HELD
  } state_t;

  state_t state;
  state_t state_nxt;

  logic        act;
  logic        mem;
  logic        mem_done;
  logic        timeout_hit;
  logic        done;
  logic        commit;
  logic [31:0] load_raw;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_value;
  logic [31:0] result;

  // Only the byte lane bits of the data address matter here.
  logic unused_addr;
  assign unused_addr = ^w_dm_addr_i[31:2];

  assign act      = w_valid_i && (state != ST_HELD);
  assign mem      = act && (w_load_i || w_store_i);
  assign mem_done = w_load_i ? dm_load_done_i : dm_store_done_i;
  assign done     = !mem || mem_done || timeout_hit;
  assign commit   = act && done;

  // The stall drops in the completion cycle itself. It also drops the moment
  // reset is applied, so an abandoned access releases the pipeline at once.
  assign w_stall_req_o = rst_n_i && mem && !done;

`ifdef URV_WB_TIMEOUT_EN
  logic [15:0] to_cnt;

  // The timeout fires on the WAIT_MEM cycle in which the count of stalled
  // cycles would reach TIMEOUT_CYCLES.
  assign timeout_hit = (state == ST_WAIT_MEM) && mem && !mem_done &&
                       (({1'b0, to_cnt} + 17'd1) == 17'(TIMEOUT_CYCLES));

  // Count WAIT_MEM cycles without a done strobe; clear on timeout or once
  // the access completes.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      to_cnt <= '0;
    end else if ((state == ST_WAIT_MEM) && mem && !mem_done && !timeout_hit) begin
      to_cnt <= to_cnt + 16'd1;
    end else begin
      to_cnt <= '0;
    end
  end

  // Bus error pulse, aligned with the register-file write of the
  // force-completed instruction.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      w_bus_err_o <= 1'b0;
    end else begin
      w_bus_err_o <= timeout_hit;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES[0];
  assign timeout_hit    = 1'b0;
  assign w_bus_err_o    = 1'b0;
`endif

  // A force-completed load returns zero rather than whatever is on the bus.
  assign load_raw = timeout_hit ? 32'd0 : dm_data_l_i;

  // Pick the byte and halfword lanes from the low address bits.
  // Misalignment is not checked.
  always_comb begin
    ld_byte = load_raw[7:0];
    case (w_dm_addr_i[1:0])
      2'd0: ld_byte = load_raw[7:0];
      2'd1: ld_byte = load_raw[15:8];
      2'd2: ld_byte = load_raw[23:16];
      2'd3: ld_byte = load_raw[31:24];
      default: ld_byte = load_raw[7:0];
    endcase
    ld_half = w_dm_addr_i[1] ? load_raw[31:16] : load_raw[15:0];
  end

  // Extend the selected lane according to funct3. Unknown sizes return the
  // full word.
  always_comb begin
    load_value = load_raw;
    case (w_fun_i)
      3'b000:  load_value = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  load_value = {24'd0, ld_byte};
      3'b001:  load_value = {{16{ld_half[15]}}, ld_half};
      3'b101:  load_value = {16'd0, ld_half};
      default: load_value = load_raw;
    endcase
  end

  // Writeback value: load data for loads, otherwise the unit named by
  // rd_source. CSR values arrive on the ALU value bus.
  always_comb begin
    result = w_rd_value_i;
    if (w_load_i) begin
      result = load_value;
    end else begin
      case (w_rd_source_i)
        2'd0:    result = w_rd_value_i;
        2'd1:    result = w_rd_shifter_i;
        2'd2:    result = w_rd_multiply_i;
        default: result = w_rd_value_i;
      endcase
    end
  end

  // Next-state logic. A commit lands in HELD whenever execute is frozen in
  // that cycle, so a long x_stall_i cannot replay the same instruction.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_WAIT_MEM: begin
        if (commit) begin
          state_nxt = x_stall_i ? ST_HELD : ST_IDLE;
        end else if (mem) begin
          state_nxt = ST_WAIT_MEM;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_HELD: begin
        if (!x_stall_i) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Registered register-file write port.
  // The strobe lasts one cycle per commit. x0, stores and non-writing ops
  // never strobe. Address and data hold between commits.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rf_rd_write_o <= 1'b0;
      rf_rd_o       <= 5'd0;
      rf_rd_value_o <= 32'd0;
    end else begin
      rf_rd_write_o <= commit && w_rd_write_i && (w_rd_i != 5'd0) && !w_store_i;
      if (commit) begin
        rf_rd_o       <= w_rd_i;
        rf_rd_value_o <= result;
      end
    end
  end

endmodule
